// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared constants and FSM encoding for the LCD text feeder.
//   CMD_LINE1 / CMD_LINE2 : DDRAM set-address commands for the start of each row
//   LINE_LEN / FRAME_LEN  : characters per row, transfers per full frame
//   lcd_state_e           : frame sequencer states
//   char_addr()           : buffer index for (row, column)
package lcd_pkg;

   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;
   localparam int         LINE_LEN  = 16;
   localparam int         FRAME_LEN = 34;
   localparam logic [3:0] LAST_COL  = 4'(LINE_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR1 = 3'd1,
      ST_LINE1 = 3'd2,
      ST_ADDR2 = 3'd3,
      ST_LINE2 = 3'd4,
      ST_DONE  = 3'd5
   } lcd_state_e;

   // Row 0 occupies buffer 0..15, row 1 occupies 16..31.
   function automatic logic [4:0] char_addr(input logic line2, input logic [3:0] col);
      return {line2, col};
   endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// lcd_char_ram -- 32 x 8 character buffer held in flops.
//   clk, rst          : clock, synchronous active-high reset (reloads the init text)
//   wr_en/addr/data   : single write port, takes effect at the clock edge
//   rd_addr, rd_data  : asynchronous read port
// Reset takes priority over a write in the same cycle.
module lcd_char_ram
   import lcd_pkg::*;
#(
   parameter logic [127:0] INIT_LINE1 = "wei zhao chun   ",
   parameter logic [127:0] INIT_LINE2 = "201484006       "
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem_q [32];
   logic [7:0] mem_d [32];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Leftmost character of each init string sits in its MSBs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LINE_LEN; i++) begin
            mem_q[i]            <= INIT_LINE1[127 - 8*i -: 8];
            mem_q[i + LINE_LEN] <= INIT_LINE2[127 - 8*i -: 8];
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lcd_text_feeder.sv
// lcd_text_feeder -- streams a 2x16 text buffer to an LCD byte/nibble driver.
//   clk, sw          : clock, synchronous active-high reset
//   wr_en/addr/data  : host character writes (0-15 row 1, 16-31 row 2)
//   refresh          : request a full resend
//   out_valid/rs/byte, out_ready : byte stream, transfer = out_valid & out_ready
//   busy, frame_done : sequencer activity, one-cycle end-of-frame pulse
//   state_dbg        : current sequencer state
// Handshake: out_valid/out_rs/out_byte are registered; once out_valid is high
// the offer is held unchanged until a rising edge sees out_ready high, and the
// next offer is loaded on that same edge so a ready sink sees no bubbles.
module lcd_text_feeder
   import lcd_pkg::*;
#(
   parameter logic [127:0] INIT_LINE1 = "wei zhao chun   ",
   parameter logic [127:0] INIT_LINE2 = "201484006       "
) (
   input  logic       clk,
   input  logic       sw,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       refresh,
   output logic       out_valid,
   output logic       out_rs,
   output logic [7:0] out_byte,
   input  logic       out_ready,
   output logic       busy,
   output logic       frame_done,
   output lcd_state_e state_dbg
);

   lcd_state_e state_q, state_d;
   logic [3:0] col_q, col_d;
   logic       valid_q, valid_d;
   logic       rs_q, rs_d;
   logic [7:0] byte_q, byte_d;
   logic       dirty_q, dirty_d;
   logic       start;
   logic       accept;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] next_char;

   lcd_char_ram #(
      .INIT_LINE1 (INIT_LINE1),
      .INIT_LINE2 (INIT_LINE2)
   ) u_ram (
      .clk     (clk),
      .rst     (sw),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign accept = valid_q & out_ready;

   // Address of the character that becomes the offer if the current one is accepted.
   always_comb begin
      rd_addr = char_addr(1'b0, 4'd0);
      case (state_q)
         ST_LINE1: rd_addr = char_addr(1'b0, col_q + 4'd1);
         ST_ADDR2: rd_addr = char_addr(1'b1, 4'd0);
         ST_LINE2: rd_addr = char_addr(1'b1, col_q + 4'd1);
         default:  rd_addr = char_addr(1'b0, 4'd0);
      endcase
   end

   // A write landing on the edge that loads that character must be sent new.
   assign next_char = (wr_en && (wr_addr == rd_addr)) ? wr_data : rd_data;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      valid_d = valid_q;
      rs_d    = rs_q;
      byte_d  = byte_q;
      start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dirty_q) begin
               start   = 1'b1;
               state_d = ST_ADDR1;
               valid_d = 1'b1;
               rs_d    = 1'b0;
               byte_d  = CMD_LINE1;
            end
         end
         ST_ADDR1: begin
            if (accept) begin
               state_d = ST_LINE1;
               col_d   = 4'd0;
               rs_d    = 1'b1;
               byte_d  = next_char;
            end
         end
         ST_LINE1: begin
            if (accept) begin
               if (col_q == LAST_COL) begin
                  state_d = ST_ADDR2;
                  col_d   = 4'd0;
                  rs_d    = 1'b0;
                  byte_d  = CMD_LINE2;
               end else begin
                  col_d  = col_q + 4'd1;
                  byte_d = next_char;
               end
            end
         end
         ST_ADDR2: begin
            if (accept) begin
               state_d = ST_LINE2;
               col_d   = 4'd0;
               rs_d    = 1'b1;
               byte_d  = next_char;
            end
         end
         ST_LINE2: begin
            if (accept) begin
               if (col_q == LAST_COL) begin
                  state_d = ST_DONE;
                  col_d   = 4'd0;
                  valid_d = 1'b0;
               end else begin
                  col_d  = col_q + 4'd1;
                  byte_d = next_char;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
      // A new event on the starting edge wins, so it is never lost.
      dirty_d = (dirty_q & ~start) | wr_en | refresh;
   end

   always_ff @(posedge clk) begin
      if (sw) begin
         state_q <= ST_IDLE;
         col_q   <= 4'd0;
         valid_q <= 1'b0;
         rs_q    <= 1'b0;
         byte_q  <= 8'h00;
         dirty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         valid_q <= valid_d;
         rs_q    <= rs_d;
         byte_q  <= byte_d;
         dirty_q <= dirty_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_rs     = rs_q;
   assign out_byte   = byte_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = (state_q == ST_DONE);
   assign state_dbg  = state_q;

endmodule
